pipe_reg_chain: RTL

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, STAGES-deep elastic pipeline register chain with a valid/ready handshake.
- Each stage holds one word plus a valid bit.
- Provides bubble collapsing, downstream back-pressure, synchronous flush and an occupancy count.
- Used between out-of-order core pipeline stages (dispatch -> issue, issue -> execute) wherever stall and flush support is needed.

---
 rtl/pipe_reg_chain.sv | 118 +++++++++++
 1 files changed

// File: rtl/pipe_reg_chain.sv
// Purpose : WIDTH-bit, STAGES-deep elastic register chain with valid/ready handshake,
//           bubble collapsing, synchronous flush and registered occupancy count.
// Latency : STAGES cycles from an input transfer to out_* when uncongested; 1 word/cycle throughput.
// Backpr. : in_ready falls only when every stage is valid and out_ready=0; empty stages always accept.
//
// Ports:
//   clk, reset (async, active-high), flush (sync, discards contents, blocks both handshakes)
//   in_valid/in_ready/in_data   - upstream handshake
//   out_valid/out_ready/out_data - downstream handshake (driven by the last stage)
//   occupancy  - number of valid stages, registered
//   parity_err - last-stage parity mismatch; only live when PIPE_REG_CHAIN_PARITY_EN is defined,
//                otherwise tied to 0 with no parity storage built.
module pipe_reg_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int CNT_W  = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] occupancy,
    output logic             parity_err
);

    logic [STAGES-1:0]            v_q, v_d;
    logic [STAGES-1:0][WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0]             occ_q, occ_d;
    logic [STAGES:0]              rdy;
`ifdef PIPE_REG_CHAIN_PARITY_EN
    logic [STAGES-1:0]            p_q, p_d;
`endif

    // Ready ripples back from the output: a stage can take a word if it is
    // empty or if the stage ahead of it is itself able to move.
    always_comb begin : ready_chain
        logic acc;
        acc         = out_ready;
        rdy[STAGES] = acc;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc    = ~v_q[i] | acc;
            rdy[i] = acc;
        end
    end

    always_comb begin : next_state
        v_d   = v_q;
        d_d   = d_q;
        occ_d = '0;
`ifdef PIPE_REG_CHAIN_PARITY_EN
        p_d   = p_q;
`endif
        if (flush) begin
            // Only the valid bits clear; payload registers keep their contents.
            v_d = '0;
        end else begin
            if (rdy[0]) begin
                v_d[0] = in_valid;
                if (in_valid) begin
                    d_d[0] = in_data;
`ifdef PIPE_REG_CHAIN_PARITY_EN
                    p_d[0] = ^in_data;
`endif
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (rdy[i]) begin
                    v_d[i] = v_q[i-1];
                    // A bubble moving in leaves the payload untouched.
                    if (v_q[i-1]) begin
                        d_d[i] = d_q[i-1];
`ifdef PIPE_REG_CHAIN_PARITY_EN
                        p_d[i] = p_q[i-1];
`endif
                    end
                end
            end
        end
        for (int i = 0; i < STAGES; i++) begin
            occ_d = occ_d + CNT_W'(v_d[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q   <= '0;
            d_q   <= '0;
            occ_q <= '0;
`ifdef PIPE_REG_CHAIN_PARITY_EN
            p_q   <= '0;
`endif
        end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            occ_q <= occ_d;
`ifdef PIPE_REG_CHAIN_PARITY_EN
            p_q   <= p_d;
`endif
        end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v_q[STAGES-1] & ~flush;
    assign out_data  = d_q[STAGES-1];
    assign occupancy = occ_q;

`ifdef PIPE_REG_CHAIN_PARITY_EN
    assign parity_err = out_valid & ((^out_data) != p_q[STAGES-1]);
`else
    assign parity_err = 1'b0;
`endif

endmodule
